// File: rtl/sort_frame_pkg.sv
// Shared constants and state encoding for the sorter frame emitter.
package sort_frame_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/sort_order_chk.sv
// Combinational monotonic check: a <= b <= c <= d, unsigned.
module sort_order_chk #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             in_order_c
);

  assign in_order_c = (a_i <= b_i) && (b_i <= c_i) && (c_i <= d_i);

endmodule

// File: rtl/sort_frame_emitter.sv
// Captures the four sorter results as a frame and streams them out one word per cycle.
// Optional build macro SORT_FRAME_ORDER_CHECK_EN adds the order_err output.
module sort_frame_emitter
  import sort_frame_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter bit          REVERSE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [WIDTH-1:0] rc,
  input  logic [WIDTH-1:0] rd,
  input  logic             load,
  output logic             load_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy
`ifdef SORT_FRAME_ORDER_CHECK_EN
  ,
  output logic             order_err
`endif
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] slot_q [FRAME_LEN];
  logic [WIDTH-1:0] slot_d [FRAME_LEN];
  logic [WIDTH-1:0] cap    [FRAME_LEN];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             last_q, last_d;

  // Capture order is fixed at elaboration by REVERSE.
  always_comb begin
    if (REVERSE) begin
      cap[0] = rd;
      cap[1] = rc;
      cap[2] = rb;
      cap[3] = ra;
    end else begin
      cap[0] = ra;
      cap[1] = rb;
      cap[2] = rc;
      cap[3] = rd;
    end
  end

  // dout/dout_last are registered copies of slot[idx] and (idx == last).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    dout_d  = dout_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          slot_d  = cap;
          idx_d   = '0;
          dout_d  = cap[0];
          last_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dout_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            dout_d  = slot_q[0];
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            dout_d = slot_q[idx_d];
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      slot_q  <= slot_d;
    end
  end

  assign dout       = dout_q;
  assign dout_last  = last_q;
  assign dout_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign load_ready = (state_q == IDLE);

`ifdef SORT_FRAME_ORDER_CHECK_EN
  logic in_order_c;
  logic order_err_q;

  sort_order_chk #(.WIDTH(WIDTH)) u_order_chk (
    .a_i        (ra),
    .b_i        (rb),
    .c_i        (rc),
    .d_i        (rd),
    .in_order_c (in_order_c)
  );

  // Judged on raw inputs at capture time, independent of REVERSE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      order_err_q <= 1'b0;
    end else if ((state_q == IDLE) && load) begin
      order_err_q <= !in_order_c;
    end
  end

  assign order_err = order_err_q;
`endif

endmodule
